// File: rtl/pooling_pkg.sv
// Shared constants, state encoding and sizing helper for the pooling datapath.
package pooling_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam logic [31:0] FLOAT32_NEG_INF    = 32'hff80_0000;

    typedef enum logic [1:0] {StIdle, StCmp, StMerge} state_e;

    // Bits needed to hold the value n itself, so an index port can express
    // out-of-range values such as n; never less than 1.
    function automatic int unsigned logb2(input int unsigned n);
        int unsigned bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((n >> i) != 0) bits = i + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/floating_comparator_sim.sv
// IEEE float32 greater-than comparator; +0 and -0 compare equal.
module floating_comparator_sim #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    localparam int unsigned EW = 8;
    localparam int unsigned MW = DATA_WIDTH - 1 - EW;

    logic a_nan;
    logic b_nan;
    logic both_zero;

    assign a_nan     = (&a[DATA_WIDTH-2 -: EW]) && (|a[MW-1:0]);
    assign b_nan     = (&b[DATA_WIDTH-2 -: EW]) && (|b[MW-1:0]);
    assign both_zero = (a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0);

    // Unordered (NaN) operands report not-greater, so a max built on this picks b.
    always_comb begin
        a_gt_b = 1'b0;
        if (a_nan || b_nan || both_zero) begin
            a_gt_b = 1'b0;
        end else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
            a_gt_b = b[DATA_WIDTH-1];
        end else if (!a[DATA_WIDTH-1]) begin
            a_gt_b = a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
        end else begin
            a_gt_b = a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
        end
    end

endmodule

// File: rtl/max_pool_window_unit.sv
// Max-pooling window unit: reduces one row segment per beat through a shared comparator,
// then merges rows vertically in a per-feature partial-max bank.
module max_pool_window_unit
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int unsigned KERNEL_SIZE   = 2,
    parameter int unsigned INPUT_SIZE    = 6,
    parameter int unsigned TOTAL_FEATURE = 4,
    localparam int unsigned FW = logb2(TOTAL_FEATURE),
    localparam int unsigned RW = logb2(INPUT_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] data_in,
    input  logic [FW-1:0]                     feature_idx,
    input  logic [RW-1:0]                     feature_row,
    input  logic                              input_valid,
    output logic                              input_ready,
    output logic                              output_valid,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic [FW-1:0]                     out_feature_idx,
    output logic [RW-1:0]                     out_row,
    output logic                              err
);

    localparam int unsigned CW         = logb2(KERNEL_SIZE);
    localparam int unsigned VALID_ROWS = (INPUT_SIZE / KERNEL_SIZE) * KERNEL_SIZE;
    localparam logic [DATA_WIDTH-1:0] NEG_INF  = DATA_WIDTH'(FLOAT32_NEG_INF);
    localparam logic [CW-1:0]         LAST_CNT = CW'(KERNEL_SIZE - 1);

    state_e                st_q, st_d;
    logic [DATA_WIDTH-1:0] seg_q [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] partial_q [TOTAL_FEATURE];
    logic [DATA_WIDTH-1:0] acc_q, data_out_q;
    logic [FW-1:0]         fidx_q, out_fidx_q;
    logic [RW-1:0]         row_q, out_row_q;
    logic [CW-1:0]         cnt_q;
    logic                  discard_q, out_valid_q, err_q;

    logic                  accept, bad_idx, bad_row, acc_gt, row_first, row_last;
    logic [DATA_WIDTH-1:0] seg_sel, part_sel, cmp_b, max_val;
    logic [31:0]           row_mod;

    assign accept    = input_valid && input_ready;
    assign bad_idx   = 32'(feature_idx) >= TOTAL_FEATURE;
    assign bad_row   = 32'(feature_row) >= VALID_ROWS;
    assign row_mod   = 32'(row_q) % KERNEL_SIZE;
    assign row_first = row_mod == 0;
    assign row_last  = row_mod == KERNEL_SIZE - 1;

    always_comb begin
        seg_sel = seg_q[0];
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (cnt_q == CW'(i)) seg_sel = seg_q[i];
        end
        part_sel = NEG_INF;
        for (int i = 0; i < TOTAL_FEATURE; i++) begin
            if (fidx_q == FW'(i)) part_sel = partial_q[i];
        end
    end

    // Single shared comparator: horizontal element in CMP, stored partial in MERGE.
    assign cmp_b   = (st_q == StMerge) ? part_sel : seg_sel;
    assign max_val = acc_gt ? acc_q : cmp_b;

    floating_comparator_sim #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
        .a     (acc_q),
        .b     (cmp_b),
        .a_gt_b(acc_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= StIdle;
        else        st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (clear) begin
            st_d = StIdle;
        end else begin
            case (st_q)
                StIdle:  if (accept) st_d = (KERNEL_SIZE == 1) ? StMerge : StCmp;
                StCmp:   if (cnt_q == LAST_CNT) st_d = StMerge;
                StMerge: st_d = StIdle;
                default: st_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KERNEL_SIZE; i++) seg_q[i] <= '0;
            for (int i = 0; i < TOTAL_FEATURE; i++) partial_q[i] <= NEG_INF;
            acc_q       <= '0;
            fidx_q      <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            out_fidx_q  <= '0;
            out_row_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            if (clear) begin
                for (int i = 0; i < TOTAL_FEATURE; i++) partial_q[i] <= NEG_INF;
            end else begin
                case (st_q)
                    StIdle: begin
                        if (accept) begin
                            for (int i = 0; i < KERNEL_SIZE; i++) begin
                                seg_q[i] <= data_in[(KERNEL_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
                            end
                            acc_q     <= data_in[KERNEL_SIZE*DATA_WIDTH-1 -: DATA_WIDTH];
                            fidx_q    <= feature_idx;
                            row_q     <= feature_row;
                            cnt_q     <= CW'(1);
                            discard_q <= bad_idx || bad_row;
                            if (bad_idx) err_q <= 1'b1;
                        end
                    end
                    StCmp: begin
                        acc_q <= max_val;
                        cnt_q <= cnt_q + CW'(1);
                    end
                    StMerge: begin
                        if (!discard_q) begin
                            for (int i = 0; i < TOTAL_FEATURE; i++) begin
                                if (fidx_q == FW'(i)) begin
                                    if (row_last)       partial_q[i] <= NEG_INF;
                                    else if (row_first) partial_q[i] <= acc_q;
                                    else                partial_q[i] <= max_val;
                                end
                            end
                            if (row_last) begin
                                out_valid_q <= 1'b1;
                                data_out_q  <= max_val;
                                out_fidx_q  <= fidx_q;
                                out_row_q   <= RW'(32'(row_q) / KERNEL_SIZE);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        input_ready     = rst_n && !clear && (st_q == StIdle);
        output_valid    = out_valid_q;
        data_out        = data_out_q;
        out_feature_idx = out_fidx_q;
        out_row         = out_row_q;
        err             = err_q;
    end

endmodule

// File: tb/tb_max_pool_window_unit.sv
// Self-checking bench for max_pool_window_unit: vector table plus hand-written corner sequences.
module tb_max_pool_window_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned K  = 2;
    localparam int unsigned FW = 3;
    localparam int unsigned RW = 3;

    logic            clk         = 1'b0;
    logic            rst_n       = 1'b0;
    logic            clear       = 1'b0;
    logic            input_valid = 1'b0;
    logic [K*DW-1:0] data_in     = '0;
    logic [FW-1:0]   feature_idx = '0;
    logic [RW-1:0]   feature_row = '0;
    logic            input_ready, output_valid, err;
    logic [DW-1:0]   data_out;
    logic [FW-1:0]   out_feature_idx;
    logic [RW-1:0]   out_row;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [FW-1:0] f;
        logic [RW-1:0] row;
        logic [DW-1:0] d;
    } exp_t;

    typedef struct {
        logic [FW-1:0] f;
        logic [RW-1:0] row;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        bit            has_out;
        logic [DW-1:0] res;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl [17];

    always #5 clk = ~clk;

    max_pool_window_unit #(
        .DATA_WIDTH   (DW),
        .KERNEL_SIZE  (K),
        .INPUT_SIZE   (7),
        .TOTAL_FEATURE(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .data_in        (data_in),
        .feature_idx    (feature_idx),
        .feature_row    (feature_row),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .output_valid   (output_valid),
        .data_out       (data_out),
        .out_feature_idx(out_feature_idx),
        .out_row        (out_row),
        .err            (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (output_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got f=%0d row=%0d data=0x%h, want no output",
                         out_feature_idx, out_row, data_out);
            end else begin
                mon_e = sb.pop_front();
                check("pooled_out", 64'({out_feature_idx, out_row, data_out}), 64'(mon_e));
            end
        end
    end

    task automatic send(input logic [FW-1:0] f, input logic [RW-1:0] r,
                        input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        int n = 0;
        @(negedge clk);
        while (!input_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!input_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got input_ready=0 for 20 cycles, want 1");
            return;
        end
        feature_idx = f;
        feature_row = r;
        data_in     = {e0, e1};
        input_valid = 1'b1;
        @(posedge clk);
        #1 input_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (5) @(negedge clk);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within time limit, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'd0, 3'd0, 32'h3f800000, 32'h40400000, 1'b0, 32'h0};
        tbl[1]  = '{3'd0, 3'd1, 32'h40000000, 32'hc0a00000, 1'b1, 32'h40400000};
        tbl[2]  = '{3'd1, 3'd0, 32'hc0800000, 32'hc0000000, 1'b0, 32'h0};
        tbl[3]  = '{3'd1, 3'd1, 32'hc0400000, 32'hc1000000, 1'b1, 32'hc0000000};
        tbl[4]  = '{3'd0, 3'd2, 32'h3f800000, 32'h3fc00000, 1'b0, 32'h0};
        tbl[5]  = '{3'd1, 3'd2, 32'h40000000, 32'h40200000, 1'b0, 32'h0};
        tbl[6]  = '{3'd2, 3'd2, 32'h40400000, 32'h40600000, 1'b0, 32'h0};
        tbl[7]  = '{3'd3, 3'd2, 32'h40800000, 32'h40900000, 1'b0, 32'h0};
        tbl[8]  = '{3'd0, 3'd3, 32'h40000000, 32'h00000000, 1'b1, 32'h40000000};
        tbl[9]  = '{3'd1, 3'd3, 32'h40400000, 32'h00000000, 1'b1, 32'h40400000};
        tbl[10] = '{3'd2, 3'd3, 32'h40800000, 32'h00000000, 1'b1, 32'h40800000};
        tbl[11] = '{3'd3, 3'd3, 32'h40a00000, 32'h00000000, 1'b1, 32'h40a00000};
        tbl[12] = '{3'd2, 3'd4, 32'h7f800000, 32'h3f800000, 1'b0, 32'h0};
        tbl[13] = '{3'd2, 3'd5, 32'h41200000, 32'h40000000, 1'b1, 32'h7f800000};
        tbl[14] = '{3'd3, 3'd4, 32'h3f000000, 32'h3e800000, 1'b0, 32'h0};
        tbl[15] = '{3'd3, 3'd6, 32'h42c80000, 32'h00000000, 1'b0, 32'h0}; // remainder row
        tbl[16] = '{3'd3, 3'd5, 32'h3dcccccd, 32'h3e4ccccd, 1'b1, 32'h3f000000};

        // Reset values
        #12;
        check("rst_ready", 64'(input_ready), 64'd0);
        check("rst_out", 64'({output_valid, data_out, out_feature_idx, out_row}), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_rst", 64'(input_ready), 64'd1);

        for (int i = 0; i < 17; i++) begin
            send(tbl[i].f, tbl[i].row, tbl[i].e0, tbl[i].e1);
            if (tbl[i].has_out) sb.push_back('{tbl[i].f, RW'(tbl[i].row / K), tbl[i].res});
        end
        drain("table_drain");

        // Exact pulse timing for a row1 beat
        send(3'd2, 3'd0, 32'h3f800000, 32'h40400000);
        send(3'd2, 3'd1, 32'h40000000, 32'hc0a00000);
        sb.push_back('{3'd2, 3'd0, 32'h40400000});
        @(negedge clk);
        check("e0_ready", 64'({input_ready, output_valid}), 64'b00);
        @(negedge clk);
        check("e1_ready", 64'({input_ready, output_valid}), 64'b00);
        @(negedge clk);
        check("e2_pulse", 64'({input_ready, output_valid, data_out}), {30'd0, 2'b11, 32'h40400000});
        @(negedge clk);
        check("e3_idle", 64'({output_valid, data_out}), 64'd0);
        drain("timing_drain");

        // Remainder row returns ready after K+1 cycles
        send(3'd0, 3'd6, 32'h42c80000, 32'h42c80000);
        @(negedge clk);
        check("rem_ready_e0", 64'(input_ready), 64'd0);
        @(negedge clk);
        check("rem_ready_e1", 64'(input_ready), 64'd0);
        @(negedge clk);
        check("rem_ready_e2", 64'(input_ready), 64'd1);

        // Clear during CMP of a row1 beat, with a competing beat held valid
        send(3'd1, 3'd0, 32'h40a00000, 32'h00000000);
        send(3'd1, 3'd1, 32'h40c00000, 32'h00000000);
        clear       = 1'b1;
        feature_idx = 3'd1;
        feature_row = 3'd3;
        data_in     = {32'h41100000, 32'h41100000};
        input_valid = 1'b1;
        @(negedge clk);
        check("clear_ready_cmp", 64'(input_ready), 64'd0);
        @(negedge clk);
        check("clear_ready_idle", 64'(input_ready), 64'd0);
        @(posedge clk);
        #1;
        clear       = 1'b0;
        input_valid = 1'b0;
        send(3'd1, 3'd2, 32'h3f000000, 32'h3e800000);
        send(3'd1, 3'd3, 32'h3dcccccd, 32'h3e4ccccd);
        sb.push_back('{3'd1, 3'd1, 32'h3f000000});
        drain("clear_drain");

        // Out-of-range feature sets a sticky err and produces nothing
        check("err_before", 64'(err), 64'd0);
        send(3'd5, 3'd1, 32'h42c80000, 32'h42c80000);
        repeat (3) @(negedge clk);
        check("err_set", 64'(err), 64'd1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("err_sticky_clear", 64'(err), 64'd1);

        // Asynchronous reset mid-CMP aborts the window and resets the bank
        send(3'd0, 3'd0, 32'h40e00000, 32'h00000000);
        send(3'd0, 3'd1, 32'h41000000, 32'h00000000);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(input_ready), 64'd0);
        check("abort_out", 64'({output_valid, data_out, out_feature_idx, out_row}), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_ready_after", 64'(input_ready), 64'd1);
        send(3'd0, 3'd1, 32'hbf800000, 32'hc0000000);
        sb.push_back('{3'd0, 3'd0, 32'hbf800000});
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
